// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the register file, the ALU and the control unit.
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_read_port.sv
// One asynchronous read port of the register file.
// It is an address-indexed mux with an optional same-cycle write bypass.
module reg_read_port #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_active,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic bypass_hit;

  // wr_active is already qualified by reset at the top level, so a pending reset
  // never forwards write data.
  always_comb begin
    bypass_hit = (BYPASS != 0) && wr_active && (rd_addr == wr_addr);
    rd_data    = bypass_hit ? wr_data : regs[rd_addr];
  end

endmodule

// File: rtl/reg_file.sv
// 8 x 8-bit general-purpose register file feeding the ALU.
// It has two combinational read ports and one synchronous write port with a synchronous reset.
module reg_file #(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1,
  parameter int BYPASS      = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Model timing only exists in simulation builds; synthesis sees zero-delay logic.
`ifdef SIMULATION
  `define RF_WDLY #(WRITE_DELAY)
  `define RF_RDLY #(READ_DELAY)
`else
  `define RF_WDLY
  `define RF_RDLY
`endif

  if (READ_DELAY < 0 || WRITE_DELAY < 0) begin : g_bad_delay
    $error("reg_file: READ_DELAY and WRITE_DELAY must be non-negative");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic              wr_active;

  // The register array is the only state.
  // Reset takes priority and drops any write in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= `RF_WDLY '0;
      end
    end else if (WRITE) begin
      regs[INADDRESS] <= `RF_WDLY IN;
    end
  end

  assign wr_active = WRITE & ~RESET;

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port1 (
    .regs      (regs),
    .rd_addr   (OUT1ADDRESS),
    .wr_active (wr_active),
    .wr_addr   (INADDRESS),
    .wr_data   (IN),
    .rd_data   (rd1_data)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port2 (
    .regs      (regs),
    .rd_addr   (OUT2ADDRESS),
    .wr_active (wr_active),
    .wr_addr   (INADDRESS),
    .wr_data   (IN),
    .rd_data   (rd2_data)
  );

  assign `RF_RDLY OUT1 = rd1_data;
  assign `RF_RDLY OUT2 = rd2_data;

`undef RF_WDLY
`undef RF_RDLY

endmodule
